fp_mul_normalize: RTL and testbench
===================================

# fp_mul_normalize

Normalisation, rounding and packing stage for the single-precision floating-point multiplier. It consumes the 48-bit raw significand product from the radix-4 mantissa multiplier, together with the operand signs and biased exponents. It emits an IEEE-754 binary32 result with overflow and underflow flags. It is a 2-stage valid/ready pipeline placed directly downstream of the radix-4 multiplier.

## Interface
- MANT_W, 24, significand width including hidden bit (product is 2*MANT_W)
- EXP_W, 8, exponent field width
- BIAS, 127, exponent bias
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  synchronous active-low reset
- in_valid  input  1  upstream product/operand fields valid
- in_ready  output  1  stage can accept input this cycle
- product  input  2*MANT_W  raw significand product, 1.xx * 1.xx in [1,4)
- sign_a, sign_b  input  1  operand signs
- exp_a, exp_b  input  EXP_W  operand biased exponents
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  32  packed binary32 {sign, exp, frac}
- overflow  output  1  result saturated to infinity
- underflow  output  1  result flushed to zero

## Operation
- Sign = sign_a ^ sign_b on every path.
- Special inputs, decoded in stage 1, take priority:
  - either exp == 255 and other exp == 0: result 0x7FC00000, flags 0.
  - either exp == 255 otherwise: ±inf (exp 0xFF, frac 0), flags 0.
  - either exp == 0: ±0, flags 0. Subnormal inputs are treated as zero.
- Normalisation in stage 1 (e is a 10-bit signed value, e = exp_a + exp_b − BIAS + n):
  - product[47] = 1: frac = product[46:24], guard = product[23], sticky = |product[22:0], n = 1.
  - otherwise: frac = product[45:23], guard = product[22], sticky = |product[21:0], n = 0.
- Rounding in stage 2: round up when guard & (sticky | frac[0]).
  - A carry out of frac (all ones + 1) gives frac = 0 and e += 1.
- Range checks after rounding:
  - e ≥ 255: ±inf, overflow = 1.
  - e ≤ 0: ±0, underflow = 1. No subnormal outputs.
  - otherwise: {sign, e[7:0], frac}.

## Timing
- Single stall-all pipeline with en = !out_valid | out_ready.
- in_ready = en. This is combinational, with no dependence on in_valid.
- Transfer occurs on in_valid & in_ready. Latency is exactly 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 per cycle.
- When out_valid & !out_ready: all stages hold, and result, overflow and underflow stay stable until accepted.
- A stage-1 bubble (in_valid = 0) propagates as out_valid = 0. There are no spurious outputs.
- Reset values: out_valid = 0, result = 32'h0, overflow = 0, underflow = 0, and internal stage valids = 0. in_ready reads 1 in the cycle after reset.
- Reset mid-operation discards all in-flight items. There is no output for them.
- Simultaneous accept and output in the same cycle is legal and required for full throughput.

## Configuration
- FP_MUL_RNE_EN defined: round-to-nearest-even as described under Operation.
- FP_MUL_RNE_EN undefined: truncation. Round-up is never applied, and guard/sticky logic is omitted. Overflow and underflow are still checked on the truncated exponent.

## Structure
- Shared package fp_pkg holds:
  - EXP_W, MANT_W and BIAS.
  - QNAN (32'h7FC00000) and the POS_INF/NEG_INF constants.
  - a packed struct for the stage-1 register: sign, e (10-bit signed), frac, guard, sticky, and a 2-bit special-case code.
- One sub-module, fp_round, contains the stage-2 rounding, range check and packing as combinational logic. The top level holds the pipeline registers and handshake.

## Test plan
- Normal, no shift: product 0x400000000000, exp_a = exp_b = 127, signs 0 → result 0x3F800000, flags 0, out_valid exactly 2 cycles after accept.
- Normal, with shift and sign: product 0x900000000000, exp 127/127, sign_a = 1 → result 0xC0100000.
- Rounding tie: product 0x400000C00000, exp 127/127 → 0x3F800002 with FP_MUL_RNE_EN, and 0x3F800001 without it.
- Overflow and underflow:
  - exp 200/200, product 0x400000000000 → 0x7F800000, overflow = 1.
  - exp 50/50 → 0x00000000, underflow = 1.
  - exp_a = 255, exp_b = 0 → 0x7FC00000.
- Backpressure: stream 3 back-to-back inputs and hold out_ready = 0 for 3 cycles → in_ready = 0 while full, result stable, then all 3 results in order with no loss or duplication.
- Mid-operation reset: rstn = 0 with 2 items in flight → out_valid = 0 and result = 0 the next cycle, and no stale result after rstn returns to 1.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and stage-1 register layout for the binary32 multiplier
// normalise/round/pack pipeline.
package fp_pkg;

   localparam int EXP_W  = 8;
   localparam int MANT_W = 24;
   localparam int FRAC_W = MANT_W - 1;
   localparam int E_W    = 10;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   localparam logic signed [E_W-1:0] E_OVF = 10'sd255;

   typedef enum logic [1:0] {
      SP_NONE,
      SP_ZERO,
      SP_INF,
      SP_NAN
   } special_e;

   typedef struct packed {
      logic                    sign;
      logic signed [E_W-1:0]   e;
      logic [FRAC_W-1:0]       frac;
      logic                    guard;
      logic                    sticky;
      special_e                special;
   } s1_t;

   function automatic logic [31:0] signed_inf(input logic sign);
      return sign ? NEG_INF : POS_INF;
   endfunction

endpackage

// File: rtl/fp_round.sv
// Stage-2 rounding, range check and binary32 packing (combinational).
// Round-to-nearest-even when FP_MUL_RNE_EN is defined, truncation otherwise.
module fp_round
   import fp_pkg::*;
(
   input  s1_t         s1,
   output logic [31:0] result,
   output logic        overflow,
   output logic        underflow
);

   logic              round_up;
   logic              carry;
   logic [FRAC_W-1:0] frac_r;
   logic [E_W-1:0]    e_sum;
   logic signed [E_W-1:0] e_r;

`ifndef FP_MUL_RNE_EN
   logic unused_rnd;
   assign unused_rnd = s1.guard ^ s1.sticky;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      round_up = 1'b0;
`ifdef FP_MUL_RNE_EN
      round_up = s1.guard & (s1.sticky | s1.frac[0]);
`endif
      {carry, frac_r} = {1'b0, s1.frac} + {{FRAC_W{1'b0}}, round_up};
      // Mantissa 1.111..1 rounding up becomes 10.000..0: frac wraps to 0, exponent bumps.
      e_sum = s1.e + {{(E_W-1){1'b0}}, carry};
      e_r   = $signed(e_sum);

      result    = '0;
      overflow  = 1'b0;
      underflow = 1'b0;
      case (s1.special)
         SP_NAN:  result = QNAN;
         SP_INF:  result = signed_inf(s1.sign);
         SP_ZERO: result = {s1.sign, 31'd0};
         default: begin
            if (e_r >= E_OVF) begin
               result   = signed_inf(s1.sign);
               overflow = 1'b1;
            end else if (e_r <= 10'sd0) begin
               result    = {s1.sign, 31'd0};
               underflow = 1'b1;
            end else begin
               result = {s1.sign, e_r[EXP_W-1:0], frac_r};
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mul_normalize.sv
// Two-stage stall-all valid/ready normalise/round/pack stage for the binary32
// multiplier. Rounding mode selected by FP_MUL_RNE_EN (undefined = truncate).
module fp_mul_normalize
   import fp_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*MANT_W-1:0]   product,
   input  logic                  sign_a,
   input  logic                  sign_b,
   input  logic [EXP_W-1:0]      exp_a,
   input  logic [EXP_W-1:0]      exp_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           result,
   output logic                  overflow,
   output logic                  underflow
);

   logic        en;
   logic        s1_valid;
   s1_t         s1_d;
   s1_t         s1_q;
   logic        shift;
   logic        a_max, b_max, a_zero, b_zero;
   logic [31:0] rnd_result;
   logic        rnd_overflow;
   logic        rnd_underflow;

`ifndef FP_MUL_RNE_EN
   logic unused_lo;
   assign unused_lo = ^product[MANT_W-2:0];
`endif

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      a_max  = (exp_a == '1);
      b_max  = (exp_b == '1);
      a_zero = (exp_a == '0);
      b_zero = (exp_b == '0);
      shift  = product[2*MANT_W-1];

      s1_d      = '0;
      s1_d.sign = sign_a ^ sign_b;
      s1_d.e    = E_W'(exp_a) + E_W'(exp_b) - E_W'(BIAS) + E_W'(shift);

      // Product in [2,4) drops one more bit below the binary point.
      if (shift) begin
         s1_d.frac   = product[2*MANT_W-2 -: FRAC_W];
`ifdef FP_MUL_RNE_EN
         s1_d.guard  = product[MANT_W-1];
         s1_d.sticky = |product[MANT_W-2:0];
`endif
      end else begin
         s1_d.frac   = product[2*MANT_W-3 -: FRAC_W];
`ifdef FP_MUL_RNE_EN
         s1_d.guard  = product[MANT_W-2];
         s1_d.sticky = |product[MANT_W-3:0];
`endif
      end

      if ((a_max && b_zero) || (b_max && a_zero)) s1_d.special = SP_NAN;
      else if (a_max || b_max)                    s1_d.special = SP_INF;
      else if (a_zero || b_zero)                  s1_d.special = SP_ZERO;
      else                                        s1_d.special = SP_NONE;
   end

   fp_round u_round (
      .s1        (s1_q),
      .result    (rnd_result),
      .overflow  (rnd_overflow),
      .underflow (rnd_underflow)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (en) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (s1_valid) begin
            result    <= rnd_result;
            overflow  <= rnd_overflow;
            underflow <= rnd_underflow;
         end
      end
   end

   // NOTE: stage-1 payload is qualified by s1_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (en && in_valid) s1_q <= s1_d;
   end

endmodule

// File: tb/tb_fp_mul_normalize.sv
// Self-checking bench for fp_mul_normalize: directed vector table, handshake
// corner sequences and randomized traffic against a behavioural model.
module tb_fp_mul_normalize;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] product;
   logic        sign_a, sign_b;
   logic [7:0]  exp_a, exp_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow, underflow;

   int n_checks = 0;
   int n_fail   = 0;

   fp_mul_normalize dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .product   (product),
      .sign_a    (sign_a),
      .sign_b    (sign_b),
      .exp_a     (exp_a),
      .exp_b     (exp_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] p;
      logic        sa;
      logic        sb;
      logic [7:0]  ea;
      logic [7:0]  eb;
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } vec_t;

`ifdef FP_MUL_RNE_EN
   localparam logic [31:0] TIE_RES    = 32'h3F80_0002;
   localparam logic [31:0] CARRY_RES  = 32'h4000_0000;
   localparam logic [31:0] C2OVF_RES  = 32'h7F80_0000;
   localparam logic        C2OVF_OVF  = 1'b1;
   localparam logic [31:0] STICKY_RES = 32'h3F80_0001;
   localparam logic [31:0] SHODD_RES  = 32'h4000_0002;
`else
   localparam logic [31:0] TIE_RES    = 32'h3F80_0001;
   localparam logic [31:0] CARRY_RES  = 32'h3FFF_FFFF;
   localparam logic [31:0] C2OVF_RES  = 32'h7F7F_FFFF;
   localparam logic        C2OVF_OVF  = 1'b0;
   localparam logic [31:0] STICKY_RES = 32'h3F80_0000;
   localparam logic [31:0] SHODD_RES  = 32'h4000_0001;
`endif

   task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Value-level reference: keep the 24-bit significand, round on the exact remainder.
   function automatic logic [33:0] ref_model(input logic [47:0] p, input logic sa, input logic sb,
                                             input logic [7:0] ea, input logic [7:0] eb);
      logic            s;
      int              e;
      int              sh;
      longint unsigned pl;
      longint unsigned m;
`ifdef FP_MUL_RNE_EN
      longint unsigned rem;
      longint unsigned half;
`endif
      s = sa ^ sb;
      if ((ea == 8'd255 && eb == 8'd0) || (eb == 8'd255 && ea == 8'd0)) return {2'b00, 32'h7FC0_0000};
      if (ea == 8'd255 || eb == 8'd255) return {2'b00, s, 8'hFF, 23'd0};
      if (ea == 8'd0 || eb == 8'd0) return {2'b00, s, 31'd0};
      pl = 64'(p);
      sh = p[47] ? 24 : 23;
      m  = pl >> sh;
      e  = int'(ea) + int'(eb) - 127 + (sh - 23);
`ifdef FP_MUL_RNE_EN
      rem  = pl & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin
         m = m >> 1;
         e = e + 1;
      end
`endif
      if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
      if (e <= 0) return {2'b01, s, 31'd0};
      return {2'b00, s, e[7:0], m[22:0]};
   endfunction

   task automatic drive(input logic [47:0] p, input logic sa, input logic sb,
                        input logic [7:0] ea, input logic [7:0] eb, input logic v);
      product  = p;
      sign_a   = sa;
      sign_b   = sb;
      exp_a    = ea;
      exp_b    = eb;
      in_valid = v;
   endtask

   function automatic logic [33:0] dut_out();
      return {overflow, underflow, result};
   endfunction

   // One isolated transaction: checks accept, the 2-cycle latency and the payload.
   task automatic run_single(input vec_t v, input int idx);
      @(negedge clk);
      out_ready = 1'b1;
      drive(v.p, v.sa, v.sb, v.ea, v.eb, 1'b1);
      #1 check($sformatf("vec%0d_in_ready", idx), 34'(in_ready), 34'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check($sformatf("vec%0d_lat1_idle", idx), 34'(out_valid), 34'd0);
      @(negedge clk);
      #1 check($sformatf("vec%0d_lat2_valid", idx), 34'(out_valid), 34'd1);
      check($sformatf("vec%0d_payload", idx), dut_out(), {v.ovf, v.unf, v.res});
   endtask

   vec_t        vecs[$];
   logic [33:0] exp_q[$];
   logic [33:0] bp_exp[3];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          got;
      logic        prev_stall;
      logic [33:0] prev_out;
      logic [33:0] e;
      logic [47:0] p;
      logic [7:0]  ea, eb;

      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b0, 8'd127, 8'd127, 32'h3F80_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h9000_0000_0000, 1'b1, 1'b0, 8'd127, 8'd127, 32'hC010_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h4000_00C0_0000, 1'b0, 1'b0, 8'd127, 8'd127, TIE_RES,       1'b0, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b0, 8'd200, 8'd200, 32'h7F80_0000, 1'b1, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b0, 8'd50,  8'd50,  32'h0000_0000, 1'b0, 1'b1});
      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b0, 8'd255, 8'd0,   32'h7FC0_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b1, 1'b0, 8'd0,   8'd255, 32'h7FC0_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b1, 1'b0, 8'd255, 8'd100, 32'hFF80_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b1, 8'd0,   8'd100, 32'h8000_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b0, 8'd191, 8'd190, 32'h7F00_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b0, 8'd191, 8'd191, 32'h7F80_0000, 1'b1, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b0, 8'd64,  8'd64,  32'h0080_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h4000_0000_0000, 1'b0, 1'b0, 8'd64,  8'd63,  32'h0000_0000, 1'b0, 1'b1});
      vecs.push_back('{48'h7FFF_FFC0_0000, 1'b0, 1'b0, 8'd127, 8'd127, CARRY_RES,     1'b0, 1'b0});
      vecs.push_back('{48'h7FFF_FFC0_0000, 1'b0, 1'b0, 8'd191, 8'd190, C2OVF_RES,     C2OVF_OVF, 1'b0});
      vecs.push_back('{48'h4000_0040_0001, 1'b0, 1'b0, 8'd127, 8'd127, STICKY_RES,    1'b0, 1'b0});
      vecs.push_back('{48'h4000_0040_0000, 1'b0, 1'b0, 8'd127, 8'd127, 32'h3F80_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h8000_0080_0000, 1'b0, 1'b0, 8'd127, 8'd127, 32'h4000_0000, 1'b0, 1'b0});
      vecs.push_back('{48'h8000_0180_0000, 1'b0, 1'b0, 8'd127, 8'd127, SHODD_RES,     1'b0, 1'b0});

      // Reset state.
      rstn      = 1'b0;
      out_ready = 1'b1;
      drive('0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      check("rst_out_valid", 34'(out_valid), 34'd0);
      check("rst_payload", dut_out(), 34'd0);
      check("rst_in_ready", 34'(in_ready), 34'd1);

      foreach (vecs[i]) run_single(vecs[i], i);

      // Backpressure: A and B fill the pipe, C waits while in_ready is low.
      bp_exp[0] = {2'b00, 32'h3F80_0000};
      bp_exp[1] = {2'b00, 32'hC010_0000};
      bp_exp[2] = {2'b10, 32'h7F80_0000};
      @(negedge clk);
      out_ready = 1'b0;
      drive(48'h4000_0000_0000, 1'b0, 1'b0, 8'd127, 8'd127, 1'b1);
      #1 check("bp_accept_a", 34'(in_ready), 34'd1);
      @(negedge clk);
      drive(48'h9000_0000_0000, 1'b1, 1'b0, 8'd127, 8'd127, 1'b1);
      #1 check("bp_accept_b", 34'(in_ready), 34'd1);
      @(negedge clk);
      drive(48'h4000_0000_0000, 1'b0, 1'b0, 8'd200, 8'd200, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_full_in_ready%0d", k), 34'(in_ready), 34'd0);
         check($sformatf("bp_hold_valid%0d", k), 34'(out_valid), 34'd1);
         check($sformatf("bp_hold_result%0d", k), dut_out(), bp_exp[0]);
         @(negedge clk);
      end
      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         #1;
         if (out_valid) begin
            if (got < 3) check($sformatf("bp_order%0d", got), dut_out(), bp_exp[got]);
            else check("bp_extra_output", 34'(out_valid), 34'd0);
            got++;
         end
         @(negedge clk);
         if (cyc == 0) in_valid = 1'b0;
      end
      check("bp_count", 34'(got), 34'd3);

      // Mid-operation reset with two items held in the pipe.
      out_ready = 1'b0;
      drive(48'h4000_0000_0000, 1'b0, 1'b0, 8'd200, 8'd200, 1'b1);
      @(negedge clk);
      drive(48'h4000_0000_0000, 1'b0, 1'b0, 8'd127, 8'd127, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("mrst_pre_valid", 34'(out_valid), 34'd1);
      rstn = 1'b0;
      @(negedge clk);
      #1;
      check("mrst_out_valid", 34'(out_valid), 34'd0);
      check("mrst_payload", dut_out(), 34'd0);
      rstn      = 1'b1;
      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         #1 if (out_valid) got++;
      end
      check("mrst_no_stale", 34'(got), 34'd0);

      // Randomized traffic with random backpressure against the reference model.
      prev_stall = 1'b0;
      prev_out   = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 3) != 0);
         p = {16'($urandom), $urandom};
         if (p[47:46] == 2'b00) p[46] = 1'b1;
         case ($urandom_range(0, 7))
            0: if (p[47]) p[23:0] = 24'h80_0000; else p[22:0] = 23'h40_0000;
            1: begin p[47:46] = 2'b01; p[45:22] = '1; end
            default: ;
         endcase
         if ($urandom_range(0, 5) == 0) begin
            ea = 8'($urandom_range(0, 255));
            eb = 8'($urandom_range(0, 255));
         end else begin
            ea = 8'($urandom_range(60, 195));
            eb = 8'($urandom_range(60, 195));
         end
         drive(p, 1'($urandom), 1'($urandom), ea, eb, ($urandom_range(0, 3) != 0));
         #1;
         check("rnd_in_ready", 34'(in_ready), 34'(!out_valid || out_ready));
         if (prev_stall) begin
            check("rnd_stall_valid", 34'(out_valid), 34'd1);
            check("rnd_stall_stable", dut_out(), prev_out);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("rnd_spurious", 34'(out_valid), 34'd0);
            else begin
               e = exp_q.pop_front();
               check("rnd_result", dut_out(), e);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = dut_out();
         if (in_valid && in_ready) exp_q.push_back(ref_model(product, sign_a, sign_b, exp_a, exp_b));
      end

      // Drain whatever is still in flight.
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         #1;
         if (out_valid) begin
            if (exp_q.size() == 0) check("drain_spurious", 34'(out_valid), 34'd0);
            else begin
               e = exp_q.pop_front();
               check("drain_result", dut_out(), e);
            end
         end
         @(negedge clk);
      end
      check("drain_empty", 34'(exp_q.size()), 34'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
